// File: rtl/node_injector.sv
// Local-port injector: buffers {dest, data} words in a FIFO and presents them to the router
// through a registered valid/ready stage with a sticky stall watchdog. Optional tx counter: NODE_INJ_STATS_EN.
module node_injector #(
  parameter int NET_WIDTH    = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int STREAM_WIDTH = DATA_WIDTH + NET_WIDTH,
  parameter int DEPTH        = 4,
  parameter int STALL_LIMIT  = 255,
  parameter int CNT_W        = $clog2(DEPTH) + 1,
  parameter int STALL_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NET_WIDTH-1:0]    req_dest,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic [STREAM_WIDTH-1:0] out_stream,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        level,
  output logic                    stall_err,
  output logic [31:0]             tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  typedef enum logic {S_EMPTY = 1'b0, S_PRESENT = 1'b1} state_t;

  logic [STREAM_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]        r_level;
  logic [CNT_W-1:0]        w_level_next;
  logic                    r_req_ready;
  state_t                  r_state;
  state_t                  w_state_next;
  logic [STREAM_WIDTH-1:0] r_out_stream;
  logic [STALL_W-1:0]      r_stall_cnt;
  logic [STALL_W-1:0]      w_stall_cnt_next;
  logic                    r_stall_err;
  logic                    w_out_valid;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_handshake;

  assign w_push      = req_valid && r_req_ready;
  assign w_handshake = w_out_valid && out_ready;
  assign w_pop       = (r_level != '0) && (!w_out_valid || out_ready);

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_dest, req_data};
    end
  end

  // Ready is registered from the next level, so a pop while full frees space only next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level     <= w_level_next;
      r_req_ready <= (w_level_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY:   if (w_pop) w_state_next = S_PRESENT;
      S_PRESENT: if (out_ready && !w_pop) w_state_next = S_EMPTY;
      default:   w_state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    w_out_valid = (r_state == S_PRESENT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_stream <= '0;
    end else if (w_pop) begin
      r_out_stream <= r_mem[r_rd_ptr];
    end
  end

  always_comb begin
    w_stall_cnt_next = '0;
    if (w_out_valid && !out_ready) begin
      w_stall_cnt_next = (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_next;
      if (w_stall_cnt_next >= STALL_W'(STALL_LIMIT)) r_stall_err <= 1'b1;
    end
  end

`ifdef NODE_INJ_STATS_EN
  logic [31:0] r_tx_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_count <= '0;
    end else if (w_handshake) begin
      r_tx_count <= r_tx_count + 32'd1;
    end
  end
  assign tx_count = r_tx_count;
`else
  assign tx_count = 32'd0;
`endif

  assign req_ready  = r_req_ready;
  assign out_valid  = w_out_valid;
  assign out_stream = r_out_stream;
  assign level      = r_level;
  assign stall_err  = r_stall_err;

endmodule

// File: doc/node_injector.md
Name: node_injector

Overview:
Source-side network interface for the node router's local input stream. Accepts payload words from the local core, each with a destination network address, and buffers them in a small FIFO. Emits each as a self-routed stream word {dest, data} with a registered valid/ready handshake into the router's local input port. Includes a stall watchdog that flags a router that stops accepting words.

Parameters:
NET_WIDTH, 4, width of destination address field (top bits of a stream word)
DATA_WIDTH, 128, payload width
STREAM_WIDTH, DATA_WIDTH+NET_WIDTH, output stream word width
DEPTH, 4, FIFO entries; power of 2, >=2
STALL_LIMIT, 255, consecutive stalled cycles before stall_err sets; >=1
CNT_W, $clog2(DEPTH)+1, width of level output
STALL_W, 8, watchdog counter width; 2^STALL_W-1 >= STALL_LIMIT

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  core offers a word
req_ready  out  1  injector can accept a word
req_dest  in  NET_WIDTH  destination address
req_data  in  DATA_WIDTH  payload
out_stream  out  STREAM_WIDTH  {dest, data}; dest in bits [STREAM_WIDTH-1 -: NET_WIDTH]
out_valid  out  1  out_stream holds a word
out_ready  in  1  router accepts the word this cycle
level  out  CNT_W  FIFO occupancy (excludes output register)
stall_err  out  1  sticky watchdog flag
tx_count  out  32  transmitted-word counter (see Optional Feature)

Behaviour:
- Reset, asynchronous, while rst=1:
  - FIFO pointers and level go to 0; out_valid=0; out_stream=0; stall counter=0; stall_err=0; tx_count=0; req_ready=0.
  - In-flight words are discarded.
  - One edge after rst deasserts, req_ready=1.
- Push: when req_valid&&req_ready at an edge, {req_dest,req_data} is written at the write pointer. req_ready = !full, from registered state only; it has no combinational path from out_ready.
- Output register has two states:
  - EMPTY (out_valid=0): if the FIFO is non-empty at an edge, load head into out_stream, pop, go to PRESENT.
  - PRESENT (out_valid=1): on out_ready=1 at an edge, the word is consumed. If the FIFO is non-empty, reload from head and pop, staying PRESENT (back-to-back, one word per cycle). Otherwise go to EMPTY.
  - While out_ready=0, out_stream and out_valid hold stable.
- Latency: a word pushed at edge t into an empty FIFO with the output register EMPTY gives out_valid=1 after edge t+1. Sustained throughput is 1 word/cycle.
- Simultaneous push and pop: level unchanged, both pointers advance, and data order is preserved. A pop does not make room for a push in the same cycle when full; req_ready stays 0 that cycle.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH; full when level==DEPTH.
- Ordering: strict FIFO. No reordering and no address inspection; the router resolves local vs neighbour delivery.
- Watchdog:
  - Counter increments each cycle with out_valid&&!out_ready and saturates at 2^STALL_W-1.
  - Counter clears on a handshake or when out_valid=0.
  - When the counter reaches STALL_LIMIT, stall_err=1 and stays set until rst. Output flow is not affected.

Optional Feature:
Macro NODE_INJ_STATS_EN.
- Defined: tx_count increments by 1 on each out_valid&&out_ready edge and wraps from 2^32-1 to 0.
- Undefined: tx_count is tied to 0 and no counter logic is synthesised.
- All other behaviour is identical in both cases.

Test Plan:
- Reset then single push (dest=4'h9, data=128'hA5) with out_ready=1 -> out_valid rises after the following edge, out_stream={4'h9,128'hA5}, consumed in 1 cycle, level returns to 0.
- Push 4 words with out_ready=0 -> the first moves to the output register and level=3. Push 2 more -> level=4, req_ready=0. Raise out_ready -> words emerge in push order, one per cycle.
- Continuous push and pop with out_ready=1 for 100 words -> 100 handshakes in order, level constant, no bubbles after the first.
- Hold out_valid with out_ready=0 for 255 cycles -> stall_err=1 at the 255th stalled cycle and stays 1 after out_ready resumes. Repeat with a handshake at cycle 254 -> stall_err stays 0.
- Assert rst asynchronously mid-stream with level=3 and out_valid=1 -> all outputs reset immediately without a clock edge; after release no stale word appears.
- With NODE_INJ_STATS_EN, transmit 10 words -> tx_count=10. Without the macro -> tx_count=0 throughout.
